// File: rtl/sram_stream_pkg.sv
// Shared types and helpers for the SRAM streaming bus masters.
package sram_stream_pkg;

   // Controller state, one-hot so each state decodes from a single bit.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      REQ  = 3'b010,
      WAIT = 3'b100
   } state_t;

   // Number of bytes carried by one bus word.
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/sram_stream_reader_sync_fifo.sv
// Synchronous FIFO with registered storage and a flush input.
// The head entry is read straight from storage, so a pushed word becomes
// visible the cycle after the push (no fall-through path from din).
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [DATA_WIDTH-1:0]   din,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic                  push_ok;
   logic                  pop_ok;

   // Flush takes priority; full/empty guard against overflow and underflow.
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   assign empty = (count_q == '0);
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign level = count_q;
   // Empty FIFO presents zero rather than stale storage.
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // Storage write; contents need no reset because dout is masked when empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sram_stream_reader.sv
// Bus master that reads a linear block of words, one request at a time,
// into a small FIFO presented as a valid/ready stream. A request is only
// issued while the FIFO has a free slot, so the FIFO cannot overflow.
module sram_stream_reader
   import sram_stream_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
   parameter int                    NUM_WORDS  = 1024,
   parameter int                    FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          i_start,
   input  logic                          i_loop,
   input  logic                          i_abort,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_bus_en,
   output logic                          o_bus_rnw,
   output logic [ADDR_WIDTH-1:0]         o_bus_addr,
   input  logic                          i_bus_data_valid,
   input  logic [DATA_WIDTH-1:0]         i_bus_data,
   output logic                          o_valid,
   output logic [DATA_WIDTH-1:0]         o_data,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int                    BPW        = bytes_per_word(DATA_WIDTH);
   localparam int                    CNT_W      = $clog2(NUM_WORDS + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPW - 1));

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      remaining_q, remaining_d;
   logic                  abort_q, abort_d;
   logic                  bus_en_q, bus_en_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic                  done_q, done_d;
   logic                  fifo_push;
   logic                  fifo_empty;
   logic                  fifo_full;

   // Next-state logic: one outstanding read, credit-gated on a free FIFO slot.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      abort_d     = abort_q;
      bus_en_d    = 1'b0;
      bus_addr_d  = bus_addr_q;
      done_d      = 1'b0;
      fifo_push   = 1'b0;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (i_start && !i_abort) begin
               addr_d      = BASE_ADDR;
               remaining_d = CNT_W'(NUM_WORDS);
               state_d     = REQ;
            end
         end
         REQ: begin
            if (i_abort) begin
               state_d = IDLE;
            end else if (!fifo_full) begin
               bus_en_d   = 1'b1;
               bus_addr_d = addr_q & ALIGN_MASK;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (i_abort) abort_d = 1'b1;
            if (i_bus_data_valid) begin
               if (abort_q || i_abort) begin
                  // The in-flight word belongs to a cancelled pass: drop it.
                  abort_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  fifo_push   = 1'b1;
                  addr_d      = addr_q + ADDR_WIDTH'(BPW);
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     if (i_loop) begin
                        addr_d      = BASE_ADDR;
                        remaining_d = CNT_W'(NUM_WORDS);
                        state_d     = REQ;
                     end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end else begin
                     state_d = REQ;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         abort_q     <= 1'b0;
         bus_en_q    <= 1'b0;
         bus_addr_q  <= BASE_ADDR;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         abort_q     <= abort_d;
         bus_en_q    <= bus_en_d;
         bus_addr_q  <= bus_addr_d;
         done_q      <= done_d;
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (fifo_push),
      .pop   (i_ready),
      .flush (i_abort),
      .din   (i_bus_data),
      .dout  (o_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (o_level)
   );

   assign o_busy     = (state_q != IDLE);
   assign o_done     = done_q;
   assign o_bus_en   = bus_en_q;
   assign o_bus_rnw  = 1'b1;
   assign o_bus_addr = bus_addr_q;
   assign o_valid    = !fifo_empty;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader (12-word block, 8-entry FIFO).
// A slave model answers each request with data equal to its address.
module tb_sram_stream_reader;

   localparam logic [31:0] BASE = 32'h80000000;
   localparam int          NW   = 12;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        i_start, i_loop, i_abort, i_ready;
   logic        o_busy, o_done, o_bus_en, o_bus_rnw, o_valid;
   logic [31:0] o_bus_addr, o_data;
   logic        i_bus_data_valid = 1'b0;
   logic [31:0] i_bus_data = '0;
   logic [3:0]  o_level;

   int n_cmp = 0;
   int n_err = 0;

   sram_stream_reader #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .BASE_ADDR  (BASE),
      .NUM_WORDS  (NW),
      .FIFO_DEPTH (8)
   ) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .i_start          (i_start),
      .i_loop           (i_loop),
      .i_abort          (i_abort),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_bus_en         (o_bus_en),
      .o_bus_rnw        (o_bus_rnw),
      .o_bus_addr       (o_bus_addr),
      .i_bus_data_valid (i_bus_data_valid),
      .i_bus_data       (i_bus_data),
      .o_valid          (o_valid),
      .o_data           (o_data),
      .i_ready          (i_ready),
      .o_level          (o_level)
   );

   always #5 clk = ~clk;

   // Slave model: returns data = address, lat cycles after the request strobe.
   int          lat   = 1;
   logic        stray = 1'b0;
   int          rsp_cnt = 0;
   logic [31:0] rsp_addr = '0;
   always @(negedge clk) begin
      i_bus_data_valid = 1'b0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            i_bus_data_valid = 1'b1;
            i_bus_data       = rsp_addr;
         end
      end
      if (o_bus_en) begin
         rsp_cnt  = lat;
         rsp_addr = o_bus_addr;
      end
      if (stray) begin
         i_bus_data_valid = 1'b1;
         i_bus_data       = 32'hDEADBEEF;
      end
   end

   // Monitor: records requests, accepted stream words and done pulses.
   logic [31:0] req_q[$];
   int          req_t[$];
   logic [31:0] rx_q[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_busy_bad = 0;
   int          b2b = 0;
   logic        en_prev = 1'b0;
   always @(posedge clk) begin
      cyc++;
      if (o_bus_en) begin
         req_q.push_back(o_bus_addr);
         req_t.push_back(cyc);
      end
      if (o_bus_en && en_prev) b2b++;
      en_prev = o_bus_en;
      if (o_valid && i_ready) rx_q.push_back(o_data);
      if (o_done) begin
         done_cnt++;
         if (o_busy) done_busy_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (o_busy && n < budget) begin
         tick(1);
         n++;
      end
      check("wait_idle_timeout", {31'd0, o_busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  {31'd0, o_busy},   32'd0);
      check({tag, "_done"},  {31'd0, o_done},   32'd0);
      check({tag, "_en"},    {31'd0, o_bus_en}, 32'd0);
      check({tag, "_valid"}, {31'd0, o_valid},  32'd0);
      check({tag, "_addr"},  o_bus_addr,        BASE);
      check({tag, "_data"},  o_data,            32'd0);
      check({tag, "_level"}, {28'd0, o_level},  32'd0);
   endtask

   initial begin
      int rqb, rxb, dnb, n;
      n_rst   = 1'b0;
      i_start = 1'b0;
      i_loop  = 1'b0;
      i_abort = 1'b0;
      i_ready = 1'b0;

      // Reset state
      tick(1);
      check_reset_outputs("reset");
      check("rnw", {31'd0, o_bus_rnw}, 32'd1);
      n_rst = 1'b1;
      tick(2);
      $display("step: reset checked");

      // Single pass, ready=1, latency 1, plus a start pulse while busy
      i_ready = 1'b1;
      rqb = req_q.size(); rxb = rx_q.size(); dnb = done_cnt;
      pulse_start();
      tick(5);
      pulse_start();
      wait_idle(300);
      tick(12);
      check("p1_nreq", req_q.size() - rqb, NW);
      for (int i = 0; i < NW; i++) begin
         check($sformatf("p1_addr%0d", i), req_q[rqb+i], BASE + 32'(4*i));
         check($sformatf("p1_data%0d", i), rx_q[rxb+i], BASE + 32'(4*i));
      end
      check("p1_nrx", rx_q.size() - rxb, NW);
      check("p1_spacing_first", req_t[rqb+1] - req_t[rqb], 3);
      check("p1_spacing_last", req_t[rqb+NW-1] - req_t[rqb+NW-2], 3);
      check("p1_done_cnt", done_cnt - dnb, 1);
      check("p1_done_while_busy", done_busy_bad, 0);
      check("p1_back_to_back_en", b2b, 0);
      $display("step: single pass, %0d requests", req_q.size() - rqb);

      // Backpressure: consumer stalled, exactly FIFO_DEPTH fetches
      i_ready = 1'b0;
      rqb = req_q.size(); rxb = rx_q.size(); dnb = done_cnt;
      pulse_start();
      tick(60);
      check("bp_nreq_stalled", req_q.size() - rqb, 8);
      check("bp_level_full", {28'd0, o_level}, 32'd8);
      check("bp_busy", {31'd0, o_busy}, 32'd1);
      check("bp_en_low", {31'd0, o_bus_en}, 32'd0);
      check("bp_head", o_data, BASE);
      i_ready = 1'b1;
      wait_idle(300);
      tick(12);
      check("bp_nreq_total", req_q.size() - rqb, NW);
      check("bp_nrx", rx_q.size() - rxb, NW);
      for (int i = 0; i < NW; i++) begin
         check($sformatf("bp_data%0d", i), rx_q[rxb+i], BASE + 32'(4*i));
      end
      check("bp_level_drained", {28'd0, o_level}, 32'd0);
      check("bp_done_cnt", done_cnt - dnb, 1);
      $display("step: backpressure pass, %0d words", rx_q.size() - rxb);

      // Looping: wrap with no gap, no done pulse
      i_loop = 1'b1;
      rqb = req_q.size(); rxb = rx_q.size(); dnb = done_cnt;
      pulse_start();
      n = 0;
      while (rx_q.size() - rxb < NW + 3 && n < 400) begin
         tick(1);
         n++;
      end
      check("loop_timeout", {31'd0, (n >= 400)}, 32'd0);
      for (int i = 0; i < NW + 3; i++) begin
         check($sformatf("loop_addr%0d", i), req_q[rqb+i], BASE + 32'(4*(i % NW)));
      end
      check("loop_wrap_spacing", req_t[rqb+NW] - req_t[rqb+NW-1], 3);
      check("loop_data_wrap", rx_q[rxb+NW], BASE);
      check("loop_no_done", done_cnt - dnb, 0);
      i_abort = 1'b1;
      tick(1);
      i_abort = 1'b0;
      i_loop  = 1'b0;
      wait_idle(50);
      tick(2);
      check("loop_abort_level", {28'd0, o_level}, 32'd0);
      check("loop_abort_no_done", done_cnt - dnb, 0);
      $display("step: loop pass, %0d words then abort", rx_q.size() - rxb);

      // Abort during WAIT with a 5-cycle slave
      i_ready = 1'b0;
      lat     = 5;
      rqb = req_q.size(); dnb = done_cnt;
      pulse_start();
      n = 0;
      while (req_q.size() - rqb < 3 && n < 200) begin
         tick(1);
         n++;
      end
      check("ab_third_req", req_q.size() - rqb, 3);
      check("ab_level_before", {28'd0, o_level}, 32'd2);
      i_abort = 1'b1;
      tick(1);
      i_abort = 1'b0;
      check("ab_level_flushed", {28'd0, o_level}, 32'd0);
      check("ab_busy_wait", {31'd0, o_busy}, 32'd1);
      tick(8);
      check("ab_idle", {31'd0, o_busy}, 32'd0);
      check("ab_level_after", {28'd0, o_level}, 32'd0);
      check("ab_valid_after", {31'd0, o_valid}, 32'd0);
      check("ab_no_more_req", req_q.size() - rqb, 3);
      check("ab_no_done", done_cnt - dnb, 0);
      lat     = 1;
      i_ready = 1'b1;
      rqb = req_q.size();
      pulse_start();
      wait_idle(300);
      check("ab_restart_addr", req_q[rqb], BASE);
      check("ab_restart_nreq", req_q.size() - rqb, NW);
      $display("step: abort in WAIT, restart at %h", req_q[rqb]);

      // Abort and start together in IDLE
      i_abort = 1'b1;
      i_start = 1'b1;
      tick(1);
      i_abort = 1'b0;
      i_start = 1'b0;
      tick(1);
      check("abort_beats_start", {31'd0, o_busy}, 32'd0);
      $display("step: abort+start in IDLE");

      // Asynchronous reset mid-pass with 3 words buffered
      i_ready = 1'b0;
      pulse_start();
      n = 0;
      while (o_level != 4'd3 && n < 200) begin
         tick(1);
         n++;
      end
      check("rst_level_before", {28'd0, o_level}, 32'd3);
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      tick(1);
      n_rst = 1'b1;
      stray = 1'b1;
      tick(2);
      stray = 1'b0;
      tick(2);
      check("rst_stray_level", {28'd0, o_level}, 32'd0);
      check("rst_stray_busy", {31'd0, o_busy}, 32'd0);
      $display("step: async reset mid-pass");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
